// File: rtl/sd_clock_monitor.sv
// SD clock monitor: synchronises an external SD clock, strobes its edges, measures
// the half-period in CLK cycles and reports lock, stall and lock-loss events.
module sd_clock_monitor #(
    parameter int unsigned LOCK_COUNT  = 2,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SD_CLK_IN,
    input  logic       EN,
    output logic       RISE,
    output logic       FALL,
    output logic [7:0] HALF_PERIOD,
    output logic       LOCKED,
    output logic       STALLED,
    output logic       ERR
);
    localparam int unsigned CW = 8;
    localparam int unsigned MW = 8;
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] STALL_VAL = CW'(STALL_LIMIT);
    localparam logic [MW-1:0] LOCK_VAL  = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_STALL   = 2'd3
    } state_t;

    state_t        state;
    logic          q1, q2, q3;
    logic [CW-1:0] cnt;
    logic [CW-1:0] prev;
    logic [MW-1:0] match;
    logic          armed;

    logic          sd_edge_c;
    logic [MW-1:0] match_next_c;

    // Edge seen on the synchronised clock; run length of equal measurements
    always_comb begin
        sd_edge_c    = q2 ^ q3;
        match_next_c = MW'(1);
        if (match != '0 && cnt == prev) begin
            match_next_c = match + MW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= S_IDLE;
            q1          <= 1'b0;
            q2          <= 1'b0;
            q3          <= 1'b0;
            cnt         <= '0;
            prev        <= '0;
            match       <= '0;
            armed       <= 1'b0;
            RISE        <= 1'b0;
            FALL        <= 1'b0;
            HALF_PERIOD <= '0;
            LOCKED      <= 1'b0;
            STALLED     <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            q1   <= SD_CLK_IN;
            q2   <= q1;
            q3   <= q2;
            RISE <= EN & q2 & ~q3;
            FALL <= EN & ~q2 & q3;
            ERR  <= 1'b0;

            if (!EN) begin
                state   <= S_IDLE;
                cnt     <= '0;
                match   <= '0;
                armed   <= 1'b0;
                LOCKED  <= 1'b0;
                STALLED <= 1'b0;
            end else begin
                if (sd_edge_c) begin
                    cnt <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end

                unique case (state)
                    S_IDLE: begin
                        cnt   <= '0;
                        match <= '0;
                        armed <= 1'b0;
                        state <= S_ACQUIRE;
                    end
                    S_ACQUIRE: begin
                        // First edge after entry only arms; the partial interval is discarded
                        if (sd_edge_c) begin
                            if (!armed) begin
                                armed <= 1'b1;
                            end else begin
                                match <= match_next_c;
                                prev  <= cnt;
                                if (match_next_c == LOCK_VAL) begin
                                    state       <= S_LOCKED;
                                    HALF_PERIOD <= cnt;
                                    LOCKED      <= 1'b1;
                                end
                            end
                        end else if (cnt == STALL_VAL) begin
                            state   <= S_STALL;
                            STALLED <= 1'b1;
                            LOCKED  <= 1'b0;
                        end
                    end
                    S_LOCKED: begin
                        if (sd_edge_c) begin
                            if (cnt != HALF_PERIOD) begin
                                state  <= S_ACQUIRE;
                                ERR    <= 1'b1;
                                LOCKED <= 1'b0;
                                match  <= MW'(1);
                                prev   <= cnt;
                                armed  <= 1'b1;
                            end
                        end else if (cnt == STALL_VAL) begin
                            state   <= S_STALL;
                            STALLED <= 1'b1;
                            LOCKED  <= 1'b0;
                        end
                    end
                    S_STALL: begin
                        // Recovery edge counts as the arming edge of a fresh acquisition
                        if (sd_edge_c) begin
                            state   <= S_ACQUIRE;
                            STALLED <= 1'b0;
                            armed   <= 1'b1;
                            match   <= '0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_clock_monitor.sv
// Randomised bench for sd_clock_monitor: an event-level reference model (edge times,
// queue of measurements) checked every cycle, plus literal checks of key scenarios.
module tb_sd_clock_monitor;
    localparam int unsigned LC = 2;
    localparam int unsigned SL = 255;

    localparam int M_IDLE = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;
    localparam int M_STALL = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SD_CLK_IN = 1'b0;
    logic       EN = 1'b0;
    logic       RISE, FALL, LOCKED, STALLED, ERR;
    logic [7:0] HALF_PERIOD;

    sd_clock_monitor #(.LOCK_COUNT(LC), .STALL_LIMIT(SL)) dut (
        .CLK(CLK), .RST(RST), .SD_CLK_IN(SD_CLK_IN), .EN(EN),
        .RISE(RISE), .FALL(FALL), .HALF_PERIOD(HALF_PERIOD),
        .LOCKED(LOCKED), .STALLED(STALLED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // SD clock generator: toggles every cur_ivl cycles; new interval adopted at a toggle
    int cur_ivl = 4;
    int ivl_next = 4;
    int ph = 0;
    always @(negedge CLK) begin
        if (cur_ivl == 0) begin
            if (ivl_next != 0) begin
                cur_ivl = ivl_next;
                ph = 0;
            end
        end else begin
            ph++;
            if (ph >= cur_ivl) begin
                SD_CLK_IN = ~SD_CLK_IN;
                ph = 0;
                cur_ivl = ivl_next;
            end
        end
    end

    // Reference model state
    bit         h0, h1, h2;
    int         mode = M_IDLE;
    bit         armed;
    int         meas_q[$];
    int         base = 0;
    int         cyc = 0;
    bit         model_valid = 1'b0;
    bit         x_rise, x_fall, x_locked, x_stalled, x_err;
    logic [7:0] x_half;
    int         err_seen = 0;
    int         stall_seen = 0;
    int         strobe_seen = 0;

    function automatic int trailing_run();
        int n = 0;
        for (int i = meas_q.size() - 1; i >= 0; i--) begin
            if (meas_q[i] != meas_q[meas_q.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit s);
        bit edg;
        int cnt;
        bit q2p, q3p;
        q2p = h1;
        q3p = h2;
        edg = q2p ^ q3p;
        if (!r) begin
            h0 = 0; h1 = 0; h2 = 0;
            x_rise = 0; x_fall = 0; x_locked = 0; x_stalled = 0; x_err = 0;
            x_half = 8'd0;
            mode = M_IDLE;
            armed = 0;
            meas_q.delete();
            base = cyc + 1;
            return;
        end
        x_rise = e & q2p & ~q3p;
        x_fall = e & ~q2p & q3p;
        h2 = h1; h1 = h0; h0 = s;
        x_err = 0;
        cnt = cyc - base;
        if (cnt > 255) cnt = 255;
        if (!e) begin
            mode = M_IDLE;
            x_locked = 0;
            x_stalled = 0;
            base = cyc + 1;
            return;
        end
        if (mode == M_IDLE) begin
            mode = M_ACQ;
            armed = 0;
            meas_q.delete();
            base = cyc + 1;
            return;
        end
        if (edg) base = cyc + 1;
        case (mode)
            M_ACQ: begin
                if (edg) begin
                    if (!armed) begin
                        armed = 1;
                    end else begin
                        meas_q.push_back(cnt);
                        if (meas_q.size() > 64) void'(meas_q.pop_front());
                        if (trailing_run() >= int'(LC)) begin
                            mode = M_LOCK;
                            x_half = 8'(cnt);
                            x_locked = 1;
                        end
                    end
                end else if (cnt == int'(SL)) begin
                    mode = M_STALL;
                    x_stalled = 1;
                    x_locked = 0;
                end
            end
            M_LOCK: begin
                if (edg) begin
                    if (cnt != int'(x_half)) begin
                        x_err = 1;
                        x_locked = 0;
                        mode = M_ACQ;
                        armed = 1;
                        meas_q.delete();
                        meas_q.push_back(cnt);
                    end
                end else if (cnt == int'(SL)) begin
                    mode = M_STALL;
                    x_stalled = 1;
                    x_locked = 0;
                end
            end
            default: begin
                if (edg) begin
                    mode = M_ACQ;
                    x_stalled = 0;
                    armed = 1;
                    meas_q.delete();
                end
            end
        endcase
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge
    bit r_s, e_s, s_s;
    always @(posedge CLK) begin
        r_s = RST;
        e_s = EN;
        s_s = SD_CLK_IN;
        model_step(r_s, e_s, s_s);
        if (!r_s) model_valid = 1'b1;
        cyc++;
        #1;
        if (model_valid) begin
            chk("rise", int'(RISE), int'(x_rise));
            chk("fall", int'(FALL), int'(x_fall));
            chk("half_period", int'(HALF_PERIOD), int'(x_half));
            chk("locked", int'(LOCKED), int'(x_locked));
            chk("stalled", int'(STALLED), int'(x_stalled));
            chk("err", int'(ERR), int'(x_err));
        end
        if (ERR === 1'b1) err_seen++;
        if (STALLED === 1'b1) stall_seen++;
        if (RISE === 1'b1 || FALL === 1'b1) strobe_seen++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b0;
        EN = 1'b0;
        cycles(3);
        chk("reset_locked", int'(LOCKED), 0);
        chk("reset_half", int'(HALF_PERIOD), 0);
        chk("reset_stalled", int'(STALLED), 0);

        // Interval 4 -> lock at 3
        RST = 1'b1;
        EN = 1'b1;
        cycles(40);
        chk("lock4_locked", int'(LOCKED), 1);
        chk("lock4_half", int'(HALF_PERIOD), 3);

        // Switch to interval 6: one ERR, relock at 5
        err_seen = 0;
        ivl_next = 6;
        cycles(45);
        chk("relock6_errs", err_seen, 1);
        chk("relock6_half", int'(HALF_PERIOD), 5);
        chk("relock6_locked", int'(LOCKED), 1);

        // Freeze -> stall
        err_seen = 0;
        ivl_next = 0;
        cycles(300);
        chk("stall_stalled", int'(STALLED), 1);
        chk("stall_locked", int'(LOCKED), 0);
        chk("stall_errs", err_seen, 0);
        ivl_next = 5;
        cycles(40);
        chk("unstall_stalled", int'(STALLED), 0);
        chk("unstall_locked", int'(LOCKED), 1);
        chk("unstall_half", int'(HALF_PERIOD), 4);

        // Interval 256: edge wins at CNT=255
        ivl_next = 256;
        cycles(20);
        stall_seen = 0;
        cycles(1100);
        chk("ivl256_stalls", stall_seen, 0);
        chk("ivl256_half", int'(HALF_PERIOD), 255);
        chk("ivl256_locked", int'(LOCKED), 1);

        // EN dropped while locked
        ivl_next = 4;
        cycles(600);
        chk("en_pre_half", int'(HALF_PERIOD), 3);
        EN = 1'b0;
        strobe_seen = 0;
        cycles(30);
        chk("en_off_locked", int'(LOCKED), 0);
        chk("en_off_half", int'(HALF_PERIOD), 3);
        chk("en_off_strobes", strobe_seen, 0);
        EN = 1'b1;
        cycles(40);
        chk("en_on_locked", int'(LOCKED), 1);

        // One-cycle reset mid-lock
        err_seen = 0;
        RST = 1'b0;
        cycles(1);
        chk("rst_mid_locked", int'(LOCKED), 0);
        chk("rst_mid_half", int'(HALF_PERIOD), 0);
        chk("rst_mid_err", int'(ERR), 0);
        RST = 1'b1;
        cycles(40);
        chk("rst_relock", int'(LOCKED), 1);
        chk("rst_relock_half", int'(HALF_PERIOD), 3);
        chk("rst_errs", err_seen, 0);

        // Randomised intervals, enables and resets
        for (int it = 0; it < 30; it++) begin
            int pick;
            pick = int'($urandom_range(0, 19));
            if (pick == 0) begin
                ivl_next = 0;
                cycles(int'($urandom_range(250, 320)));
            end else if (pick <= 2) begin
                ivl_next = int'($urandom_range(250, 260));
                cycles(int'($urandom_range(600, 900)));
            end else begin
                ivl_next = int'($urandom_range(1, 14));
                cycles(int'($urandom_range(20, 120)));
            end
            pick = int'($urandom_range(0, 19));
            if (pick < 2) begin
                EN = 1'b0;
                cycles(int'($urandom_range(1, 8)));
                EN = 1'b1;
            end else if (pick == 2) begin
                RST = 1'b0;
                cycles(int'($urandom_range(1, 3)));
                RST = 1'b1;
            end
        end
        cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sd_clock_monitor.md
SD_CLOCK_MONITOR -- requirements
Module: sd_clock_monitor

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 2: consecutive identical half-period measurements required to lock.
REQ-002 SHALL have parameter STALL_LIMIT, default 255: value of the idle counter at which the clock is declared stalled.
REQ-003 SHALL have port CLK  in  1  system clock; the only clock in the block.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port SD_CLK_IN  in  1  observed SD clock; asynchronous to CLK.
REQ-006 SHALL have port EN  in  1  monitor enable.
REQ-007 SHALL have port RISE  out  1  one-cycle strobe on a detected SD_CLK_IN rising edge.
REQ-008 SHALL have port FALL  out  1  one-cycle strobe on a detected SD_CLK_IN falling edge.
REQ-009 SHALL have port HALF_PERIOD  out  8  last locked half-period, in the same encoding as the clock-divider DIVIDER value.
REQ-010 SHALL have port LOCKED  out  1  measurement is stable.
REQ-011 SHALL have port STALLED  out  1  no SD_CLK_IN edge for STALL_LIMIT cycles.
REQ-012 SHALL have port ERR  out  1  one-cycle strobe on a lost lock.

Function
REQ-013 SHALL sample SD_CLK_IN through a 3-flop chain q1->q2->q3; internal strobe edge = q2^q3.
REQ-014 SHALL register RISE = EN & q2 & ~q3 and FALL = EN & ~q2 & q3; a strobe is high for exactly one cycle, starting at the 3rd CLK edge that samples the new level.
REQ-015 SHALL keep an 8-bit counter CNT: 0 on a cycle with edge, otherwise CNT+1, saturating at 255; measurement = CNT value on an edge cycle (DIVIDER=D gives measurement D).
REQ-016 SHALL implement FSM states IDLE, ACQUIRE, LOCKED, STALL.
REQ-017 IDLE: CNT, match counter and first-edge flag held at 0; the next cycle goes to ACQUIRE when EN=1.
REQ-018 ACQUIRE: the first edge only arms the measurement (partial interval discarded); each later edge compares the measurement with the previous one: equal -> match+1, else match=1.
REQ-019 ACQUIRE -> LOCKED when match reaches LOCK_COUNT; HALF_PERIOD <= that measurement in the same cycle, and LOCKED=1 from the next cycle.
REQ-020 LOCKED: an edge whose measurement differs from HALF_PERIOD -> ERR pulse for 1 cycle, LOCKED=0, go to ACQUIRE with match=1 and that measurement as previous; HALF_PERIOD is retained.
REQ-021 ACQUIRE/LOCKED: CNT==STALL_LIMIT with no edge in that cycle -> STALL; STALLED=1, LOCKED=0, no ERR.
REQ-022 STALL: the next edge -> ACQUIRE, STALLED=0, and that edge is treated as the first (arming) edge.
REQ-023 Simultaneous edge and CNT==STALL_LIMIT: the edge wins and no stall is declared.
REQ-024 EN=0 in any state -> IDLE on the next cycle; LOCKED, STALLED, ERR=0; HALF_PERIOD is retained; RISE/FALL are suppressed.
REQ-025 The synchronizer chain SHALL run regardless of EN.

Reset
REQ-026 On a CLK edge with RST=0: q1..q3=0, CNT=0, match=0, state=IDLE, RISE=FALL=ERR=0, LOCKED=STALLED=0, HALF_PERIOD=0.
REQ-027 Reset applied mid-lock SHALL take effect on the next CLK edge with no ERR pulse; after release the monitor relocks from ACQUIRE.

Verification
REQ-028 EN=1, SD_CLK_IN driven with toggle interval 4 CLK (DIVIDER=3) -> RISE/FALL alternate every 4 cycles, HALF_PERIOD=3, LOCKED=1 after the 3rd edge (first edge arms, then 2 matches).
REQ-029 Locked at 3, interval switched to 6 -> one ERR pulse, LOCKED=0; after 2 further intervals of 6, HALF_PERIOD=5 and LOCKED=1.
REQ-030 Locked, SD_CLK_IN frozen -> STALLED=1 when CNT reaches 255, LOCKED=0; the next edge clears STALLED and lock returns after LOCK_COUNT matching intervals.
REQ-031 Interval 256 (DIVIDER=255) -> no stall (edge wins at CNT=255), HALF_PERIOD=255, LOCKED=1.
REQ-032 EN dropped while locked -> IDLE, LOCKED=0, no strobes, HALF_PERIOD unchanged; EN re-raised -> relock.
REQ-033 RST=0 asserted for 1 cycle mid-lock -> all outputs 0 on the next edge, no ERR pulse, relock follows.
